tile_map_writer: RTL and testbench
==================================

# tile_map_writer

Write scheduler and arbiter for the 64 x 320-bit screen tile map memory (64 rows of 80 four-bit tile indices, one row per 8 scanlines). It accepts single-tile update requests from game/control logic, buffers them in a small FIFO, and performs read-modify-write cycles on the map only during vertical blanking. Outside those cycles it passes the display's read address straight to the memory. It sits between the tile-select display path and the single-port map RAM.

## Interface
- VTOP, 10'd31: last blanking line before the visible area; visible lines are VTOP+1 .. VTOP+VLINES.
- VLINES, 10'd480: visible line count.
- NCOLS, 7'd80: tiles per map row; valid columns are 0..NCOLS-1.
- FIFO_DEPTH, 4: request buffer depth, power of two.

- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- vcount  in  10  current scanline from the sync generator
- disp_addr  in  6  display-side map row address
- wr_valid  in  1  update request valid
- wr_ready  out  1  request accepted when wr_valid & wr_ready at a rising edge
- wr_row  in  6  target map row
- wr_col  in  7  target column
- wr_tile  in  4  new tile index
- mem_addr  out  6  RAM address
- mem_we  out  1  RAM write enable, registered
- mem_din  out  320  RAM write data, registered
- mem_dout  in  320  RAM read data; synchronous RAM with 1-cycle read latency
- busy  out  1  read-modify-write in progress
- fifo_level  out  3  current FIFO occupancy, 0..FIFO_DEPTH
- drop_cnt  out  8  saturating count of requests discarded for wr_col >= NCOLS

## Operation
- FIFO
  - wr_ready = (fifo_level != FIFO_DEPTH).
  - A push stores {row, col, tile}.
  - Pops happen only from the FSM in IDLE.
  - A push and a pop in the same cycle leave the level unchanged.
  - A newly pushed entry is visible to the FSM on the following cycle; there is no bypass.
- Window
  - win = (vcount <= VTOP-1) | (vcount > VTOP+VLINES).
  - Line VTOP itself is a guard line: no new RMW starts on it.
- FSM states: IDLE, RD, CAP, WR.
  - IDLE: if FIFO non-empty and win, pop the head into cur_row, cur_col, cur_tile.
    - If cur_col >= NCOLS: increment drop_cnt (saturating at 255) and stay in IDLE.
    - Otherwise go to RD.
  - RD: mem_addr = cur_row, mem_we = 0. Go to CAP.
  - CAP: line_reg <= mem_dout with bits [4*cur_col+3 : 4*cur_col] replaced by cur_tile. Go to WR.
  - WR: mem_we = 1, mem_din = line_reg, mem_addr = cur_row. Go to IDLE.
- An RMW that has started always completes, even if win drops mid-sequence.
- Address mux:
  - mem_addr = cur_row in RD and WR.
  - mem_addr = disp_addr in IDLE and CAP.
- busy = (state != IDLE).
- Requests to the same row execute in FIFO order. Each RMW reads the previous write's result, so back-to-back updates to one row both take effect.

## Timing
- Reset values (immediate on rst_n low):
  - state = IDLE, FIFO empty, fifo_level = 0, wr_ready = 1.
  - mem_we = 0, mem_din = 0, busy = 0, drop_cnt = 0.
  - cur_* and line_reg = 0.
- Reset mid-RMW aborts it: no write is issued and all queued requests are lost.
- Latency:
  - Push at edge t: earliest pop at edge t+1.
  - RD occupies cycle t+1, CAP cycle t+2, WR cycle t+3.
  - RAM write occurs at edge t+4.
- Throughput: one tile update per 4 cycles; one dropped request per cycle.
- The FIFO can be filled while win = 0; entries wait until the next blanking window.

## Test plan
- Reset, win open, push (row 5, col 0, tile 4'hA) -> mem_we pulses exactly one cycle, 3 cycles after pop, at addr 5, with mem_din[3:0] = 4'hA and all other bits equal to the prior row contents.
- Push (row 63, col 79, tile 4'hF) then (row 63, col 78, tile 4'h3) back-to-back -> two writes 4 cycles apart; the final row holds bits [319:316] = F and [315:312] = 3.
- vcount = 100 (visible), push 5 requests -> the first 4 are accepted, wr_ready = 0, fifo_level = 4, mem_we never asserts. Moving vcount to 0 drains the FIFO in 16 cycles.
- Push col 80 and col 127 -> drop_cnt = 2, no mem_we, FIFO empty after 2 pops. 300 invalid pushes -> drop_cnt saturates at 255.
- Start an RMW at vcount = 30, then step vcount to 32 during CAP -> WR still completes. A second queued entry is not started until win reasserts. disp_addr reaches mem_addr while the FSM is in IDLE/CAP.
- Assert rst_n low during CAP -> mem_we stays 0, fifo_level = 0, wr_ready = 1, busy = 0 immediately.

Source files
------------

// File: rtl/tile_map_writer.sv
// rtl/tile_map_writer.sv - buffered tile-map updater doing read-modify-write during vertical blanking
// Display reads own the RAM address except in RD and WR, when the current update's row is driven.
module tile_map_writer #(
  parameter logic [9:0] VTOP       = 10'd31,
  parameter logic [9:0] VLINES     = 10'd480,
  parameter logic [6:0] NCOLS      = 7'd80,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [9:0]   vcount,
  input  logic [5:0]   disp_addr,
  input  logic         wr_valid,
  output logic         wr_ready,
  input  logic [5:0]   wr_row,
  input  logic [6:0]   wr_col,
  input  logic [3:0]   wr_tile,
  output logic [5:0]   mem_addr,
  output logic         mem_we,
  output logic [319:0] mem_din,
  input  logic [319:0] mem_dout,
  output logic         busy,
  output logic [2:0]   fifo_level,
  output logic [7:0]   drop_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RD, CAP, WR} state_t;

  state_t         state_q, state_d;
  logic [16:0]    fifo_q [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PW:0]    level_q;
  logic [5:0]     cur_row_q, cur_row_d;
  logic [6:0]     cur_col_q, cur_col_d;
  logic [3:0]     cur_tile_q, cur_tile_d;
  logic [319:0]   line_q, line_d;
  logic           we_q, we_d;
  logic [7:0]     drop_q, drop_d;
  logic           push, pop, win;
  logic [16:0]    head;
  logic [8:0]     nib_idx;

  assign win        = (vcount <= VTOP - 10'd1) | (vcount > VTOP + VLINES);
  assign wr_ready   = (level_q != (PW+1)'(FIFO_DEPTH));
  assign push       = wr_valid & wr_ready;
  assign head       = fifo_q[rd_ptr_q];
  assign nib_idx    = {cur_col_q, 2'b00};
  assign busy       = (state_q != IDLE);
  assign fifo_level = level_q;
  assign drop_cnt   = drop_q;
  assign mem_we     = we_q;
  assign mem_din    = line_q;

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    cur_row_d  = cur_row_q;
    cur_col_d  = cur_col_q;
    cur_tile_d = cur_tile_q;
    line_d     = line_q;
    we_d       = 1'b0;
    drop_d     = drop_q;
    mem_addr   = disp_addr;
    case (state_q)
      IDLE: begin
        if (level_q != '0 && win) begin
          pop        = 1'b1;
          cur_row_d  = head[16:11];
          cur_col_d  = head[10:4];
          cur_tile_d = head[3:0];
          if (head[10:4] >= NCOLS) begin
            if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        mem_addr = cur_row_q;
        state_d  = CAP;
      end
      CAP: begin
        // RAM data for cur_row arrives this cycle; merge the new nibble into it
        line_d                = mem_dout;
        line_d[nib_idx +: 4]  = cur_tile_q;
        we_d                  = 1'b1;
        state_d               = WR;
      end
      WR: begin
        mem_addr = cur_row_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      cur_row_q  <= '0;
      cur_col_q  <= '0;
      cur_tile_q <= '0;
      line_q     <= '0;
      we_q       <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      cur_row_q  <= cur_row_d;
      cur_col_q  <= cur_col_d;
      cur_tile_q <= cur_tile_d;
      line_q     <= line_d;
      we_q       <= we_d;
      drop_q     <= drop_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      level_q <= level_q + 1'b1;
      else if (!push && pop) level_q <= level_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= {wr_row, wr_col, wr_tile};
  end

endmodule

// File: tb/tb_tile_map_writer.sv
// tb/tb_tile_map_writer.sv - directed bench with a write scoreboard checked by a mem_we monitor
module tb_tile_map_writer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [9:0]   vcount;
  logic [5:0]   disp_addr;
  logic         wr_valid;
  logic         wr_ready;
  logic [5:0]   wr_row;
  logic [6:0]   wr_col;
  logic [3:0]   wr_tile;
  logic [5:0]   mem_addr;
  logic         mem_we;
  logic [319:0] mem_din;
  logic [319:0] mem_dout;
  logic         busy;
  logic [2:0]   fifo_level;
  logic [7:0]   drop_cnt;

  tile_map_writer dut (
    .clk(clk), .rst_n(rst_n), .vcount(vcount), .disp_addr(disp_addr),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_row(wr_row), .wr_col(wr_col),
    .wr_tile(wr_tile), .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din),
    .mem_dout(mem_dout), .busy(busy), .fifo_level(fifo_level), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]   addr;
    logic [319:0] data;
  } wr_t;

  wr_t          exp_q[$];
  int           we_cyc[$];
  int           checks = 0;
  int           errors = 0;
  int           we_count = 0;
  int           cyc = 0;
  logic         load_ram = 1'b1;
  logic [319:0] ram    [64];
  logic [319:0] shadow [64];

  function automatic logic [319:0] row_init(int r);
    logic [319:0] v;
    for (int i = 0; i < 10; i++) v[i*32 +: 32] = {8'hC3, 8'(i), 8'(r), 8'h5A};
    return v;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (load_ram) begin
      for (int r = 0; r < 64; r++) ram[r] <= row_init(r);
    end else begin
      if (mem_we) ram[mem_addr] <= mem_din;
      mem_dout <= ram[mem_addr];
    end
  end

  // Monitor: every RAM write must match the oldest expected write
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      wr_t e;
      we_count++;
      we_cyc.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr %0d with empty scoreboard", mem_addr);
      end else begin
        e = exp_q.pop_front();
        if (mem_addr !== e.addr || mem_din !== e.data) begin
          errors++;
          $display("FAIL write_data: got addr %0d data %h, expected addr %0d data %h",
                   mem_addr, mem_din, e.addr, e.data);
        end
      end
    end
  end

  task automatic chk(string name, logic [319:0] act, logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [5:0] r, input logic [6:0] c, input logic [3:0] t, input bit sb);
    wr_t e;
    wr_valid = 1'b1; wr_row = r; wr_col = c; wr_tile = t;
    if (sb) begin
      shadow[r][{c, 2'b00} +: 4] = t;
      e.addr = r;
      e.data = shadow[r];
      exp_q.push_back(e);
    end
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle(string name);
    int n;
    n = 0;
    while ((busy || fifo_level != 0) && n < 80) begin
      tick();
      n++;
    end
    chk({name, "_idle_timeout"}, 32'(n >= 80), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc;
    for (int r = 0; r < 64; r++) shadow[r] = row_init(r);
    rst_n = 1'b0; vcount = 10'd0; disp_addr = 6'd3; wr_valid = 1'b0;
    wr_row = '0; wr_col = '0; wr_tile = '0;
    #2;
    chk("rst_mem_we", mem_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ready", wr_ready, 1);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_din", mem_din, 0);
    chk("rst_addr", mem_addr, 3);
    tick(); load_ram = 1'b0; tick();
    rst_n = 1'b1;
    tick();

    // Single update at row 5 col 0, cycle-by-cycle
    disp_addr = 6'd17;
    push(6'd5, 7'd0, 4'hA, 1);
    chk("t1_level", fifo_level, 1);
    chk("t1_idle", busy, 0);
    tick();
    chk("t1_rd_busy", busy, 1);
    chk("t1_rd_addr", mem_addr, 5);
    tick();
    chk("t1_cap_addr", mem_addr, 17);
    chk("t1_cap_we", mem_we, 0);
    tick();
    chk("t1_wr_we", mem_we, 1);
    chk("t1_wr_addr", mem_addr, 5);
    tick();
    chk("t1_done_we", mem_we, 0);
    chk("t1_done_busy", busy, 0);
    chk("t1_ram_row5", ram[5], shadow[5]);

    // Back-to-back updates to one row
    we_cyc.delete();
    push(6'd63, 7'd79, 4'hF, 1);
    push(6'd63, 7'd78, 4'h3, 1);
    wait_idle("t2");
    tick();
    chk("t2_nwrites", we_cyc.size(), 2);
    if (we_cyc.size() == 2) chk("t2_spacing", we_cyc[1] - we_cyc[0], 4);
    chk("t2_top_nibbles", ram[63][319:312], 8'hF3);
    chk("t2_row63", ram[63], shadow[63]);

    // Fill while visible; fifth request refused
    vcount = 10'd100;
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1; wr_row = 6'(10 + i); wr_col = 7'(i + 1); wr_tile = 4'(i + 1);
      chk("t3_ready", wr_ready, (i < 4) ? 1 : 0);
      if (i < 4) begin
        wr_t e;
        shadow[10 + i][{7'(i + 1), 2'b00} +: 4] = 4'(i + 1);
        e.addr = 6'(10 + i);
        e.data = shadow[10 + i];
        exp_q.push_back(e);
      end
      tick();
    end
    wr_valid = 1'b0;
    chk("t3_level_full", fifo_level, 4);
    chk("t3_ready_full", wr_ready, 0);
    wc = we_count;
    repeat (10) tick();
    chk("t3_no_write_visible", we_count, wc);
    vcount = 10'd0;
    repeat (15) tick();
    chk("t3_busy_15", busy, 1);
    tick();
    chk("t3_busy_16", busy, 0);
    chk("t3_level_16", fifo_level, 0);
    chk("t3_writes_16", we_count, wc + 4);

    // Out-of-range columns are dropped
    wc = we_count;
    push(6'd1, 7'd80, 4'h1, 0);
    push(6'd2, 7'd127, 4'h2, 0);
    tick();
    chk("t4_drop2", drop_cnt, 2);
    chk("t4_level", fifo_level, 0);
    chk("t4_busy", busy, 0);
    wr_valid = 1'b1; wr_row = 6'd4; wr_col = 7'd100; wr_tile = 4'h4;
    repeat (300) tick();
    wr_valid = 1'b0;
    repeat (3) tick();
    chk("t4_drop_sat", drop_cnt, 255);
    chk("t4_no_write", we_count, wc);

    // Window closes mid-RMW; guard line does not start a new one
    vcount = 10'd30; disp_addr = 6'd9;
    push(6'd20, 7'd5, 4'h7, 1);
    push(6'd21, 7'd6, 4'h2, 1);
    tick();
    chk("t5_cap_busy", busy, 1);
    chk("t5_cap_addr", mem_addr, 9);
    vcount = 10'd32;
    tick();
    chk("t5_wr_we", mem_we, 1);
    chk("t5_wr_addr", mem_addr, 20);
    tick();
    chk("t5_idle_busy", busy, 0);
    chk("t5_idle_addr", mem_addr, 9);
    repeat (5) tick();
    chk("t5_hold_busy", busy, 0);
    chk("t5_hold_level", fifo_level, 1);
    vcount = 10'd31;
    repeat (3) tick();
    chk("t5_guard_busy", busy, 0);
    chk("t5_guard_level", fifo_level, 1);
    vcount = 10'd600;
    wait_idle("t5");
    tick();
    chk("t5_row20", ram[20], shadow[20]);
    chk("t5_row21", ram[21], shadow[21]);

    // Reset during CAP aborts the write and empties the queue
    vcount = 10'd0;
    wc = we_count;
    push(6'd30, 7'd1, 4'h5, 0);
    push(6'd31, 7'd2, 4'h6, 0);
    tick();
    chk("t6_cap_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_we", mem_we, 0);
    chk("t6_level", fifo_level, 0);
    chk("t6_ready", wr_ready, 1);
    chk("t6_busy", busy, 0);
    chk("t6_drop", drop_cnt, 0);
    tick(); tick();
    rst_n = 1'b1;
    repeat (8) tick();
    chk("t6_no_write", we_count, wc);
    chk("t6_row30", ram[30], shadow[30]);
    chk("t6_row31", ram[31], shadow[31]);

    chk("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
